uart_block_rx: RTL and testbench
================================

UART_BLOCK_RX -- requirements
Module: uart_block_rx

Interface
REQ-001 SHALL have parameter CLOCK_PER_BIT, default 10417, clock cycles per serial bit (100 MHz / 9600 baud).
REQ-002 SHALL have parameter TIMEOUT_BITS, default 32, bit periods of idle line mid-block before the partial block is discarded.
REQ-003 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset; one clock, reset asynchronous and active-high.
REQ-005 SHALL have port rx  input  1  asynchronous UART serial line; idle high; 8N1, LSB first.
REQ-006 SHALL have port data  output  128  assembled block; first received byte in [127:120], sixteenth in [7:0].
REQ-007 SHALL have port data_state  output  1  one-cycle pulse: data holds a new complete block.
REQ-008 SHALL have port byte_count  output  5  bytes accepted into the current partial block, 0..15.
REQ-009 SHALL have port frame_err  output  1  one-cycle pulse: stop bit sampled low.

Function
REQ-010 SHALL pass rx through a two-flop synchronizer; all decisions use the synchronized value.
REQ-011 SHALL implement states IDLE, START, DATA, STOP.
REQ-012 IDLE: synchronized rx low -> START, with the bit counter cleared.
REQ-013 START: after CLOCK_PER_BIT/2 cycles, sample rx; low -> DATA; high -> IDLE as a glitch, with no byte and no error.
REQ-014 DATA: sample rx every CLOCK_PER_BIT cycles at bit centre, 8 samples, LSB first -> STOP.
REQ-015 STOP: after CLOCK_PER_BIT cycles, sample rx.
REQ-016 STOP sample high: the byte is accepted into the shift register and byte_count increments -> IDLE.
REQ-017 STOP sample low: frame_err pulses, the byte is dropped, byte_count is unchanged, and the FSM enters IDLE only after rx returns high.
REQ-018 On acceptance of the 16th byte, data SHALL load the full block and data_state SHALL pulse high on the same clock edge as that stop-bit sample; byte_count wraps to 0.
REQ-019 data SHALL hold its value until the next complete block; partial blocks never alter data.
REQ-020 data_state and frame_err SHALL never be high for more than one consecutive cycle.
REQ-021 Bit-timing counter width SHALL be ceil(log2(CLOCK_PER_BIT*TIMEOUT_BITS+1)); no overflow at any legal parameter value.
REQ-022 A new falling edge arriving in the same cycle that STOP completes SHALL be detected in IDLE on the next cycle, with no byte lost at back-to-back frames.

Reset
REQ-023 On rst: FSM=IDLE, counters=0, byte_count=0, data=0, data_state=0, frame_err=0, synchronizer flops=1.
REQ-024 rst asserted mid-byte or mid-block SHALL discard all partial data; reception restarts at the next start bit after release.

Configuration
REQ-025 With macro UART_RX_TIMEOUT_EN defined: while byte_count!=0 and the FSM is in IDLE for TIMEOUT_BITS*CLOCK_PER_BIT cycles, byte_count SHALL clear to 0 and the partial block is discarded; data is unchanged and no pulse is generated.
REQ-026 Without UART_RX_TIMEOUT_EN: no timeout logic is built, and a partial block persists indefinitely.

Structure
REQ-027 A shared package SHALL hold the FSM state encoding, BLOCK_BYTES=16, the default CLOCK_PER_BIT and TIMEOUT_BITS, and the baud constants (clock_speed, baud_rate).
REQ-028 A single sub-module uart_rx_byte SHALL contain the synchronizer, the FSM, and bit sampling, emitting byte plus valid/err strobes; the top SHALL do block assembly and timeout.

Verification (CLOCK_PER_BIT=16, TIMEOUT_BITS=4)
REQ-029 Send bytes 0x00..0x0F back-to-back -> data=128'h000102030405060708090A0B0C0D0E0F; data_state high exactly one cycle; byte_count=0 afterwards.
REQ-030 Low glitch of 5 cycles on idle rx -> no state change beyond START, byte_count unchanged, no pulses.
REQ-031 Byte 0xA5 with stop bit low -> frame_err one-cycle pulse; byte_count unchanged; the following 16 good bytes 0x10..0x1F assemble correctly.
REQ-032 Assert rst after 7 bytes, then send 16 bytes 0xFF..0xF0 -> data=128'hFFFEFDFCFBFAF9F8F7F6F5F4F3F2F1F0, with exactly one data_state pulse.
REQ-033 With UART_RX_TIMEOUT_EN: send 3 bytes, idle 70 cycles, send 16 bytes 0x20..0x2F -> data=128'h202122232425262728292A2B2C2D2E2F; without the macro, the first data_state instead fires after the 13th byte of the second burst (0x2C), with data=128'h0XXXXX plus bytes 0x20..0x2C, where the first three bytes are the earlier burst.

Source files
------------

// File: rtl/uart_block_rx_pkg.sv
// Shared definitions for the UART block receiver: FSM encoding, block size,
// baud constants and the bit-timing counter width helper.
package uart_block_rx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } rx_state_t;

   localparam int BLOCK_BYTES = 16;

   localparam int clock_speed = 100_000_000;
   localparam int baud_rate   = 9600;

   // Rounded to nearest: 100 MHz / 9600 baud -> 10417.
   localparam int DEFAULT_CLOCK_PER_BIT = (clock_speed + baud_rate / 2) / baud_rate;
   localparam int DEFAULT_TIMEOUT_BITS  = 32;

   // Wide enough to count a full idle timeout without overflow.
   function automatic int timer_width(input int clock_per_bit, input int timeout_bits);
      return $clog2(clock_per_bit * timeout_bits + 1);
   endfunction

endpackage

// File: rtl/uart_block_rx_byte.sv
// Single-byte 8N1 receiver: rx synchronizer, IDLE/START/DATA/STOP FSM and
// bit-centre sampling; emits the byte with one-cycle valid/err strobes.
module uart_rx_byte
   import uart_block_rx_pkg::*;
#(
   parameter int CLOCK_PER_BIT = DEFAULT_CLOCK_PER_BIT,
   parameter int CNT_W         = timer_width(DEFAULT_CLOCK_PER_BIT, DEFAULT_TIMEOUT_BITS)
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] rx_byte,
   output logic       byte_valid,
   output logic       byte_err,
   output logic       rx_idle
);

   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLOCK_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLOCK_PER_BIT - 1);

   logic             rx_meta;
   logic             rx_sync;
   rx_state_t        state;
   logic [CNT_W-1:0] tick;
   logic [2:0]       bit_idx;
   logic [7:0]       shift_reg;
   logic             stop_wait;

   // NOTE: synchronizer flops reset to the idle level so release never fakes a start bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_sync <= rx_meta;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         tick       <= '0;
         bit_idx    <= '0;
         shift_reg  <= '0;
         stop_wait  <= 1'b0;
         byte_valid <= 1'b0;
         byte_err   <= 1'b0;
      end else begin
         // NOTE: strobes default low every cycle, so each assertion lasts exactly one clock.
         byte_valid <= 1'b0;
         byte_err   <= 1'b0;
         case (state)
            ST_IDLE: begin
               tick      <= '0;
               bit_idx   <= '0;
               stop_wait <= 1'b0;
               if (!rx_sync) state <= ST_START;
            end
            ST_START: begin
               if (tick == HALF_LAST) begin
                  tick  <= '0;
                  state <= rx_sync ? ST_IDLE : ST_DATA;
               end else begin
                  tick <= tick + 1'b1;
               end
            end
            ST_DATA: begin
               if (tick == FULL_LAST) begin
                  tick      <= '0;
                  shift_reg <= {rx_sync, shift_reg[7:1]};
                  if (bit_idx == 3'd7) state <= ST_STOP;
                  else                 bit_idx <= bit_idx + 3'd1;
               end else begin
                  tick <= tick + 1'b1;
               end
            end
            ST_STOP: begin
               if (stop_wait) begin
                  // Bad stop bit: hold off until the line is back to idle.
                  if (rx_sync) state <= ST_IDLE;
               end else if (tick == FULL_LAST) begin
                  tick <= '0;
                  if (rx_sync) begin
                     byte_valid <= 1'b1;
                     state      <= ST_IDLE;
                  end else begin
                     byte_err  <= 1'b1;
                     stop_wait <= 1'b1;
                  end
               end else begin
                  tick <= tick + 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign rx_byte = shift_reg;
   assign rx_idle = (state == ST_IDLE);

endmodule

// File: rtl/uart_block_rx.sv
// UART block receiver: collects 16 bytes into a 128-bit block (first byte in
// the MSBs). Define UART_RX_TIMEOUT_EN to discard stale partial blocks.
module uart_block_rx
   import uart_block_rx_pkg::*;
#(
   parameter int CLOCK_PER_BIT = DEFAULT_CLOCK_PER_BIT,
   parameter int TIMEOUT_BITS  = DEFAULT_TIMEOUT_BITS
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         rx,
   output logic [127:0] data,
   output logic         data_state,
   output logic [4:0]   byte_count,
   output logic         frame_err
);

   localparam int CNT_W  = timer_width(CLOCK_PER_BIT, TIMEOUT_BITS);
   localparam int SHR_W  = (BLOCK_BYTES - 1) * 8;

   logic [7:0]       rx_byte;
   logic             byte_valid;
   logic             rx_idle;
   logic [SHR_W-1:0] shift_reg;
   logic             timeout_hit;

   uart_rx_byte #(
      .CLOCK_PER_BIT(CLOCK_PER_BIT),
      .CNT_W        (CNT_W)
   ) u_rx_byte (
      .clk       (clk),
      .rst       (rst),
      .rx        (rx),
      .rx_byte   (rx_byte),
      .byte_valid(byte_valid),
      .byte_err  (frame_err),
      .rx_idle   (rx_idle)
   );

`ifdef UART_RX_TIMEOUT_EN
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(CLOCK_PER_BIT * TIMEOUT_BITS - 1);
   logic [CNT_W-1:0] idle_cnt;

   assign timeout_hit = rx_idle && (byte_count != 5'd0) && (idle_cnt == TIMEOUT_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                              idle_cnt <= '0;
      else if (!rx_idle || byte_count == 5'd0 || timeout_hit) idle_cnt <= '0;
      else                                                  idle_cnt <= idle_cnt + 1'b1;
   end
`else
   logic unused_idle;
   assign unused_idle = rx_idle;
   assign timeout_hit = 1'b0;
`endif

   // NOTE: data is an output register, not storage, so it takes a reset value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shift_reg  <= '0;
         data       <= '0;
         data_state <= 1'b0;
         byte_count <= 5'd0;
      end else begin
         data_state <= 1'b0;
         if (byte_valid) begin
            if (byte_count == 5'(BLOCK_BYTES - 1)) begin
               data       <= {shift_reg, rx_byte};
               data_state <= 1'b1;
               byte_count <= 5'd0;
            end else begin
               shift_reg  <= {shift_reg[SHR_W-9:0], rx_byte};
               byte_count <= byte_count + 5'd1;
            end
         end else if (timeout_hit) begin
            byte_count <= 5'd0;
         end
      end
   end

endmodule

// File: tb/tb_uart_block_rx.sv
// Randomized bench for uart_block_rx against a byte-queue reference model.
module tb_uart_block_rx;

   localparam int CPB = 16;
   localparam int TOB = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         rx;
   logic [127:0] data;
   logic         data_state;
   logic [4:0]   byte_count;
   logic         frame_err;

   always #5 clk = ~clk;

   uart_block_rx #(.CLOCK_PER_BIT(CPB), .TIMEOUT_BITS(TOB)) dut (
      .clk       (clk),
      .rst       (rst),
      .rx        (rx),
      .data      (data),
      .data_state(data_state),
      .byte_count(byte_count),
      .frame_err (frame_err)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference model: bytes of the current partial block and blocks still due.
   logic [7:0]   partial[$];
   logic [127:0] exp_blocks[$];
   int           exp_errs    = 0;
   int           seen_errs   = 0;
   int           seen_pulses = 0;
   logic [127:0] last_data   = '0;
   logic [127:0] held        = '0;
   logic         prev_ds     = 1'b0;
   logic         prev_fe     = 1'b0;

   task automatic model_accept(input logic [7:0] b);
      logic [127:0] blk;
      partial.push_back(b);
      if (partial.size() == 16) begin
         blk = '0;
         foreach (partial[i]) blk = {blk[119:0], partial[i]};
         exp_blocks.push_back(blk);
         partial.delete();
      end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         prev_ds = 1'b0;
         prev_fe = 1'b0;
         held    = '0;
      end else begin
         if (data_state) begin
            seen_pulses++;
            last_data = data;
            held      = data;
            check("ds_one_cycle", 128'(prev_ds), 128'd0);
            if (exp_blocks.size() == 0) check("block_expected", 128'(data_state), 128'd0);
            else                        check("block_data", data, exp_blocks.pop_front());
         end else if (data !== held) begin
            check("data_hold", data, held);
            held = data;
         end
         if (frame_err) begin
            seen_errs++;
            check("fe_one_cycle", 128'(prev_fe), 128'd0);
         end
         prev_ds = data_state;
         prev_fe = frame_err;
      end
   end

   task automatic send_byte(input logic [7:0] b, input bit stop_ok);
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (CPB) @(negedge clk);
      end
      if (stop_ok) model_accept(b);
      else         exp_errs++;
      rx = stop_ok;
      repeat (CPB) @(negedge clk);
      check("byte_count", 128'(byte_count), 128'(partial.size()));
      check("frame_err_count", 128'(seen_errs), 128'(exp_errs));
      rx = 1'b1;
      if (!stop_ok) repeat (CPB) @(negedge clk);
   endtask

   task automatic idle_gap(input int n);
      rx = 1'b1;
      repeat (n) @(negedge clk);
`ifdef UART_RX_TIMEOUT_EN
      if (partial.size() != 0 && CPB / 2 + n >= CPB * TOB) partial.delete();
`endif
      if (n > 0) check("byte_count_gap", 128'(byte_count), 128'(partial.size()));
   endtask

   initial begin
      int p0;
      int e0;
      int gap;
      int r;
      rst = 1'b1;
      rx  = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_data", data, 128'd0);
      check("rst_data_state", 128'(data_state), 128'd0);
      check("rst_byte_count", 128'(byte_count), 128'd0);
      check("rst_frame_err", 128'(frame_err), 128'd0);
      rst = 1'b0;
      idle_gap(10);

      // Sixteen back-to-back bytes 0x00..0x0F.
      p0 = seen_pulses;
      for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b1);
      idle_gap(20);
      check("blk_0f_data", last_data, 128'h000102030405060708090A0B0C0D0E0F);
      check("blk_0f_pulses", 128'(seen_pulses - p0), 128'd1);
      check("blk_0f_count", 128'(byte_count), 128'd0);

      // Short low glitch on an idle line.
      p0 = seen_pulses;
      e0 = seen_errs;
      rx = 1'b0;
      repeat (5) @(negedge clk);
      idle_gap(30);
      check("glitch_pulses", 128'(seen_pulses - p0), 128'd0);
      check("glitch_errs", 128'(seen_errs - e0), 128'd0);

      // Framing error, then a clean block.
      p0 = seen_pulses;
      send_byte(8'hA5, 1'b0);
      for (int i = 0; i < 16; i++) send_byte(8'(8'h10 + i), 1'b1);
      idle_gap(20);
      check("blk_1f_data", last_data, 128'h101112131415161718191A1B1C1D1E1F);
      check("blk_1f_pulses", 128'(seen_pulses - p0), 128'd1);

      // Reset mid-block discards the partial bytes.
      for (int i = 0; i < 7; i++) send_byte(8'($urandom), 1'b1);
      rst = 1'b1;
      partial.delete();
      exp_blocks.delete();
      repeat (3) @(negedge clk);
      check("midrst_data", data, 128'd0);
      check("midrst_count", 128'(byte_count), 128'd0);
      rst = 1'b0;
      idle_gap(10);
      p0 = seen_pulses;
      for (int i = 0; i < 16; i++) send_byte(8'(8'hFF - i), 1'b1);
      idle_gap(20);
      check("blk_f0_data", last_data, 128'hFFFEFDFCFBFAF9F8F7F6F5F4F3F2F1F0);
      check("blk_f0_pulses", 128'(seen_pulses - p0), 128'd1);

      // Partial block followed by a long idle line.
      p0 = seen_pulses;
      send_byte(8'h55, 1'b1);
      send_byte(8'h66, 1'b1);
      send_byte(8'h77, 1'b1);
      idle_gap(70);
      for (int i = 0; i < 16; i++) send_byte(8'(8'h20 + i), 1'b1);
      idle_gap(20);
      check("timeout_pulses", 128'(seen_pulses - p0), 128'd1);
`ifdef UART_RX_TIMEOUT_EN
      check("timeout_data", last_data, 128'h202122232425262728292A2B2C2D2E2F);
      check("timeout_count", 128'(byte_count), 128'd0);
`else
      check("no_timeout_data", last_data, 128'h556677202122232425262728292A2B2C);
      check("no_timeout_count", 128'(byte_count), 128'd3);
`endif

      // Random traffic: occasional bad stop bits, short and long idle gaps.
      for (int n = 0; n < 60; n++) begin
         send_byte(8'($urandom), $urandom_range(0, 9) != 0);
         r = $urandom_range(0, 9);
         if (r < 7)      gap = 0;
         else if (r < 9) gap = $urandom_range(1, 20);
         else            gap = $urandom_range(80, 100);
         idle_gap(gap);
      end
      idle_gap(40);
      check("blocks_drained", 128'(exp_blocks.size()), 128'd0);
      check("total_errs", 128'(seen_errs), 128'(exp_errs));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
